// File: rtl/fc_pkg.sv
// Shared FC constants and readout FSM state encoding.
package fc_pkg;

  localparam int unsigned FC_DW      = 16;
  localparam int unsigned FC_RAM_NUM = 4;
  localparam int unsigned FC_N_OUT   = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fc_skid_fifo.sv
// Two-entry first-word-fall-through buffer; entry 0 is always the head.
module fc_skid_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [1:0][Width-1:0] mem_q, mem_d;
  logic [1:0]            cnt_q, cnt_d;

  // Pop shifts entry 1 down; push lands in the first free slot after the pop.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop_i && (cnt_q != 2'd0)) begin
      mem_d[0] = mem_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (push_i && (cnt_d != 2'd2)) begin
      mem_d[cnt_d[0]] = push_data_i;
      cnt_d           = cnt_d + 2'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = mem_q[0];
  assign count_o = cnt_q;

endmodule

// File: rtl/fc_readout_argmax.sv
// Walks the FC result bank in index order, streams each value (optionally ReLU'd)
// and tracks the signed argmax of the raw values as the class decision.
module fc_readout_argmax
  import fc_pkg::*;
#(
  parameter int unsigned DW      = FC_DW,
  parameter int unsigned RAM_NUM = FC_RAM_NUM,
  parameter int unsigned N_OUT   = FC_N_OUT,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned IDX_W   = 8,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [3:0]        ram_select,
  output logic [ADDR_W-1:0] addr_r,
  output logic              RA_enable,
  input  logic [DW-1:0]     rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              done,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DW-1:0]     class_max
);

  localparam int unsigned        EntW    = DW + IDX_W + 1;
  localparam logic [IDX_W-1:0]   LastIdx = IDX_W'(N_OUT - 1);
  localparam logic [3:0]         LastBnk = 4'(RAM_NUM - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        bank_q, bank_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic              inflight_q;
  logic [IDX_W-1:0]  inflight_idx_q;
  logic [DW-1:0]     max_q, max_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W-1:0]  class_idx_q;
  logic [DW-1:0]     class_max_q;

  logic              issue;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic [DW-1:0]     push_val;
  logic [EntW-1:0]   push_ent, head_ent;

  assign pop = out_valid & out_ready;
  // Slots already claimed once this cycle's pop is taken into account.
  assign occ = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);

  // Next-state logic: FSM, bank/row walk and read issue.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    k_d     = k_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          bank_d  = 4'd0;
          row_d   = '0;
          k_d     = '0;
        end
      end
      ST_READ: begin
        if (occ < 3'd2) begin
          issue = 1'b1;
          k_d   = k_q + IDX_W'(1);
          if (bank_q == LastBnk) begin
            bank_d = 4'd0;
            row_d  = row_q + ADDR_W'(1);
          end else begin
            bank_d = bank_q + 4'd1;
          end
          if (k_q == LastIdx) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Every element is already buffered; finish once the last one is taken.
        if (pop && out_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Running argmax on raw signed data as it enters the buffer; strict > keeps lowest index.
  always_comb begin
    max_d     = max_q;
    max_idx_d = max_idx_q;
    if (inflight_q &&
        ((inflight_idx_q == '0) || ($signed(rd_data) > $signed(max_q)))) begin
      max_d     = rd_data;
      max_idx_d = inflight_idx_q;
    end
  end

  assign push_val = (RELU_EN && rd_data[DW-1]) ? '0 : rd_data;
  assign push_ent = {push_val, inflight_idx_q, (inflight_idx_q == LastIdx)};

  // Sequential state; class result loads on entry to DONE so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bank_q         <= 4'd0;
      row_q          <= '0;
      k_q            <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      max_q          <= '0;
      max_idx_q      <= '0;
      class_idx_q    <= '0;
      class_max_q    <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      k_q        <= k_d;
      inflight_q <= issue;
      if (issue) inflight_idx_q <= k_q;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      if (state_d == ST_DONE) begin
        class_idx_q <= max_idx_q;
        class_max_q <= max_q;
      end
    end
  end

  fc_skid_fifo #(
    .Width(EntW)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (inflight_q),
    .push_data_i(push_ent),
    .pop_i      (pop),
    .valid_o    (out_valid),
    .head_o     (head_ent),
    .count_o    (fifo_cnt)
  );

  assign out_data   = head_ent[EntW-1 -: DW];
  assign out_idx    = head_ent[IDX_W:1];
  assign out_last   = head_ent[0];
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign RA_enable  = issue;
  assign ram_select = bank_q;
  assign addr_r     = row_q;
  assign class_idx  = class_idx_q;
  assign class_max  = class_max_q;

endmodule
